// File: rtl/hp_pack_round_if.sv
// hp_pack_round_if: operand-in / packed-result-out handshake bundle.
// master drives operands and out_ready; slave is the packer.
interface hp_pack_round_if #(
  parameter int NEXP   = 8,
  parameter int NSIG   = 7,
  parameter int NGUARD = 3
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          in_sign;
  logic signed [NEXP+1:0]        in_exp;
  logic        [NSIG+NGUARD:0]   in_sig;
  logic        [5:0]             in_class;
  logic                          out_valid;
  logic                          out_ready;
  logic        [NEXP+NSIG:0]     out_bf;
  logic        [4:0]             out_flags;

  modport master (
    output in_valid, in_sign, in_exp,
    output in_sig, in_class, out_ready,
    input  in_ready, out_valid,
    input  out_bf, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp,
    input  in_sig, in_class, out_ready,
    output in_ready, out_valid,
    output out_bf, out_flags
  );
endinterface

// File: rtl/hp_pack_round.sv
// hp_pack_round: unpacked sign/exp/sig -> packed bf16-style word, RNE.
// Define HP_PACK_FTZ_EN to flush tiny results instead of denormalizing.
module hp_pack_round #(
  parameter int NEXP   = 8,
  parameter int NSIG   = 7,
  parameter int NGUARD = 3
) (
  input logic            clk,
  input logic            rst_n,
  hp_pack_round_if.slave io
);
  localparam int SW   = NSIG + 1 + NGUARD;
  localparam int EW   = NEXP + 2;
  localparam int BW   = NEXP + NSIG + 1;
  localparam int KMAX = NSIG + NGUARD + 2;
  localparam int CW   = $clog2(KMAX + 1);

  localparam logic signed [EW-1:0] BIAS =
    EW'((1 << (NEXP - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX =
    EW'((1 << NEXP) - 1);
  localparam logic signed [EW:0] KMAX_S =
    (EW + 1)'(KMAX);
  localparam logic [BW-1:0] QNAN =
    {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ROUND,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    K_NUM,
    K_ZERO,
    K_INF,
    K_QNAN,
    K_SNAN,
    K_FTZ
  } kind_e;

  state_e               state_q, state_d;
  kind_e                kind_q, kind_d;
  logic                 sign_q, sign_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [SW-1:0]        sig_q, sig_d;
  logic                 sticky_q, sticky_d;
  logic                 tiny_q, tiny_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bf_q, bf_d;
  logic [4:0]           flags_q, flags_d;

  logic                 in_ready;
  logic                 accept;
  logic signed [EW-1:0] biased;
  logic signed [EW:0]   kfull;
  logic [CW-1:0]        k_in;
  kind_e                kind_in;

  logic                 lsb, g, rs, inc;
  logic                 carry, inexact, ovf;
  logic [NSIG+1:0]      mant;
  logic [NSIG-1:0]      frac;
  logic signed [EW-1:0] exp_r;
  logic [BW-1:0]        res_bf;
  logic [4:0]           res_fl;

  assign in_ready     = (state_q == S_IDLE) && rst_n;
  assign accept       = io.in_valid && in_ready;
  assign io.in_ready  = in_ready;
  assign io.out_valid = (state_q == S_DONE);
  assign io.out_bf    = bf_q;
  assign io.out_flags = flags_q;

  // Operand classification at accept time
  always_comb begin
    biased  = io.in_exp + BIAS;
    kfull   = {{EW{1'b0}}, 1'b1}
            - {biased[EW-1], biased};
    k_in    = (kfull > KMAX_S) ? CW'(KMAX)
                               : kfull[CW-1:0];
    kind_in = K_NUM;
    unique case (1'b1)
      io.in_class[5]: kind_in = K_SNAN;
      io.in_class[4]: kind_in = K_QNAN;
      io.in_class[3]: kind_in = K_INF;
      io.in_class[2]: kind_in = K_ZERO;
      io.in_class[1]: kind_in = K_NUM;
      io.in_class[0]: kind_in = K_NUM;
      default:        kind_in = K_NUM;
    endcase
    if (kind_in == K_NUM && io.in_sig == '0)
      kind_in = K_ZERO;
  end

  // Round-to-nearest-even and result packing
  always_comb begin
    lsb   = sig_q[NGUARD];
    g     = sig_q[NGUARD-1];
    rs    = (|sig_q[NGUARD-2:0]) | sticky_q;
    inc   = g & (lsb | rs);
    mant  = {1'b0, sig_q[SW-1:NGUARD]}
          + {{(NSIG+1){1'b0}}, inc};
    carry = mant[NSIG+1];
    frac  = carry ? mant[NSIG:1]
                  : mant[NSIG-1:0];
    // a tiny value that rounds up into the hidden bit becomes exp 1
    exp_r = tiny_q
          ? {{(EW-1){1'b0}}, mant[NSIG]}
          : exp_q + {{(EW-1){1'b0}}, carry};
    inexact = g | rs;
    ovf     = (exp_r >= EMAX);
    res_bf  = '0;
    res_fl  = '0;
    unique case (kind_q)
      K_ZERO: begin
        res_bf = {sign_q, {(BW-1){1'b0}}};
      end
      K_INF: begin
        res_bf = {sign_q, {NEXP{1'b1}},
                  {NSIG{1'b0}}};
      end
      K_QNAN: begin
        res_bf = QNAN;
      end
      K_SNAN: begin
        res_bf = QNAN;
        res_fl = 5'b00001;
      end
      K_FTZ: begin
        res_bf = {sign_q, {(BW-1){1'b0}}};
        res_fl = 5'b11000;
      end
      default: begin
        if (ovf) begin
          res_bf = {sign_q, {NEXP{1'b1}},
                    {NSIG{1'b0}}};
          res_fl = 5'b10100;
        end else begin
          res_bf = {sign_q, exp_r[NEXP-1:0], frac};
          res_fl = {inexact, tiny_q & inexact,
                    3'b000};
        end
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    sig_d    = sig_q;
    sticky_d = sticky_q;
    tiny_d   = tiny_q;
    cnt_d    = cnt_q;
    bf_d     = bf_q;
    flags_d  = flags_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          sign_d   = io.in_sign;
          sig_d    = io.in_sig;
          sticky_d = 1'b0;
          tiny_d   = 1'b0;
          exp_d    = biased;
          cnt_d    = k_in;
          kind_d   = kind_in;
          state_d  = S_ROUND;
          if (kind_in == K_NUM && biased < 1) begin
            tiny_d = 1'b1;
            exp_d  = '0;
`ifdef HP_PACK_FTZ_EN
            kind_d = K_FTZ;
`else
            state_d = S_SHIFT;
`endif
          end
        end
      end
      S_SHIFT: begin
        sig_d    = sig_q >> 1;
        sticky_d = sticky_q | sig_q[0];
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1))
          state_d = S_ROUND;
      end
      S_ROUND: begin
        bf_d    = res_bf;
        flags_d = res_fl;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (io.out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      kind_q   <= K_NUM;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      sig_q    <= '0;
      sticky_q <= 1'b0;
      tiny_q   <= 1'b0;
      cnt_q    <= '0;
      bf_q     <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      sig_q    <= sig_d;
      sticky_q <= sticky_d;
      tiny_q   <= tiny_d;
      cnt_q    <= cnt_d;
      bf_q     <= bf_d;
      flags_q  <= flags_d;
    end
  end
endmodule

// File: tb/tb_hp_pack_round.sv
// tb_hp_pack_round: scoreboard bench for hp_pack_round (bf16 config).
// Expected words, flags and latency are queued at issue, checked at output.
module tb_hp_pack_round;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef HP_PACK_FTZ_EN
  localparam bit FTZ = 1'b1;
`else
  localparam bit FTZ = 1'b0;
`endif

  localparam logic [5:0] C_NORM = 6'b000001;
  localparam logic [5:0] C_ZERO = 6'b000100;
  localparam logic [5:0] C_INF  = 6'b001000;
  localparam logic [5:0] C_QNAN = 6'b010000;
  localparam logic [5:0] C_SNAN = 6'b100000;

  hp_pack_round_if #(.NEXP(8), .NSIG(7), .NGUARD(3)) bus ();

  hp_pack_round #(.NEXP(8), .NSIG(7), .NGUARD(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  typedef struct {
    logic [15:0] bf;
    logic [4:0]  fl;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic send(input logic s, input int e,
                      input logic [10:0] m,
                      input logic [5:0] c,
                      input logic [15:0] bf,
                      input logic [4:0] fl,
                      input int lat);
    int   w = 0;
    exp_t x;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = 10'(e);
    bus.in_sig   = m;
    bus.in_class = c;
    x.bf  = bf;
    x.fl  = fl;
    x.lat = lat;
    sb.push_back(x);
    @(posedge clk);
  endtask

  task automatic recv(input int stall);
    int   lat = 1;
    exp_t x;
    logic [15:0] bf0;
    logic [4:0]  fl0;
    bus.out_ready = (stall == 0);
    @(negedge clk);
    // keep in_valid high with junk: it must be ignored while busy
    bus.in_sign  = ~bus.in_sign;
    bus.in_exp   = 10'($urandom_range(0, 200));
    bus.in_sig   = 11'($urandom);
    bus.in_class = C_NORM;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("out_valid", 32'(bus.out_valid), 32'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check("latency", 32'(lat), 32'(x.lat));
      check("out_bf", 32'(bus.out_bf), 32'(x.bf));
      check("out_flags", 32'(bus.out_flags), 32'(x.fl));
    end
    bf0 = bus.out_bf;
    fl0 = bus.out_flags;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_bf", 32'(bus.out_bf), 32'(bf0));
      check("hold_flags", 32'(bus.out_flags), 32'(fl0));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("valid_drop", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_sig    = '0;
    bus.in_class  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_bf", 32'(bus.out_bf), 32'd0);
    check("rst_out_flags", 32'(bus.out_flags), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;

    send(0, 0, 11'b1_0000000_000, C_NORM, 16'h3F80, 5'b00000, 2);
    recv(0);
    send(0, 0, 11'b1_0000001_100, C_NORM, 16'h3F82, 5'b10000, 2);
    recv(0);
    send(0, 0, 11'b1_0000000_100, C_NORM, 16'h3F80, 5'b10000, 2);
    recv(0);
    send(0, 0, 11'b1_0000000_101, C_NORM, 16'h3F81, 5'b10000, 2);
    recv(0);
    send(1, -126, 11'b1_0101010_000, C_NORM, 16'h80AA, 5'b00000, 2);
    recv(0);
    send(0, 127, 11'b1_1111111_100, C_NORM, 16'h7F80, 5'b10100, 2);
    recv(0);
    send(0, 128, 11'b1_0000000_000, C_NORM, 16'h7F80, 5'b10100, 2);
    recv(0);
    send(0, -127, 11'b1_0000000_000, C_NORM,
         FTZ ? 16'h0000 : 16'h0040,
         FTZ ? 5'b11000 : 5'b00000, FTZ ? 2 : 3);
    recv(0);
    send(0, -134, 11'b1_0000000_001, C_NORM,
         FTZ ? 16'h0000 : 16'h0001, 5'b11000, FTZ ? 2 : 10);
    recv(0);
    send(0, -127, 11'b1_1111111_100, C_NORM,
         FTZ ? 16'h0000 : 16'h0080, 5'b11000, FTZ ? 2 : 3);
    recv(0);
    send(1, -140, 11'b1_0000000_000, C_NORM,
         16'h8000, 5'b11000, FTZ ? 2 : 14);
    recv(0);
    send(1, 3, 11'b0, C_ZERO, 16'h8000, 5'b00000, 2);
    recv(0);
    send(0, 5, 11'b0, C_NORM, 16'h0000, 5'b00000, 2);
    recv(0);
    send(1, 0, 11'b0, C_INF, 16'hFF80, 5'b00000, 2);
    recv(0);
    send(1, 0, 11'b1_1000000_000, C_QNAN, 16'h7FC0, 5'b00000, 2);
    recv(0);
    send(1, 0, 11'b1_0100000_000, C_SNAN, 16'h7FC0, 5'b00001, 2);
    recv(5);

    // reset while the subnormal is being denormalized
    send(0, -134, 11'b1_0000000_001, C_NORM, 16'h0001, 5'b11000, 10);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_bf", 32'(bus.out_bf), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    if (sb.size() != 0) void'(sb.pop_front());
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("postrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("postrst_out_valid", 32'(bus.out_valid), 32'd0);

    send(0, 0, 11'b1_0000001_100, C_NORM, 16'h3F82, 5'b10000, 2);
    recv(0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
